// File: rtl/rgb_contrast_inv.sv
// Inverse contrast map for RGB pixels: undoes the three-segment stretch of rgb_contrast_adj.
// Channels share one mapping datapath, sequenced R->G->B by a five-state FSM.
module rgb_contrast_inv (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       en_i,
    input  logic       valid_i,
    output logic       ready_i,
    input  logic [7:0] r_i,
    input  logic [7:0] g_i,
    input  logic [7:0] b_i,
    output logic       valid_o,
    input  logic       ready_o,
    output logic [7:0] r_o,
    output logic [7:0] g_o,
    output logic [7:0] b_o
);

    localparam logic [7:0] L1      = 8'd42;
    localparam logic [7:0] L2      = 8'd213;
    localparam logic [7:0] R1      = 8'd85;
    localparam logic [7:0] R2      = 8'd170;
    localparam logic [7:0] MID_MAX = 8'd210;
    localparam logic [7:0] GAP_VAL = 8'd169;

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] CALC_R = 3'd1;
    localparam logic [2:0] CALC_G = 3'd2;
    localparam logic [2:0] CALC_B = 3'd3;
    localparam logic [2:0] OUT    = 3'd4;

    // Every segment result fits in 8 bits, so the arithmetic never needs a carry bit.
    function automatic logic [7:0] inv_map(input logic [7:0] y);
        logic [7:0] x;
        if (y < L1) begin
            x = y << 1;
        end else if (y <= MID_MAX) begin
            x = R1 + ((y - L1) >> 1);
        end else if (y < L2) begin
            x = GAP_VAL;
        end else begin
            x = R2 + ((y - L2) << 1);
        end
        return x;
    endfunction

    logic [2:0] state_q, state_d;
    logic       valid_q, ready_q, en_q;
    logic [7:0] r_q, g_q, b_q;
    logic [7:0] r_out_q, g_out_q, b_out_q;
    logic [7:0] ch_in_s, ch_out_s;

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (valid_i) begin
                    state_d = CALC_R;
                end else begin
                    state_d = IDLE;
                end
            end
            CALC_R: state_d = CALC_G;
            CALC_G: state_d = CALC_B;
            CALC_B: state_d = OUT;
            OUT: begin
                if (ready_o) begin
                    state_d = IDLE;
                end else begin
                    state_d = OUT;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Shared channel datapath: pick the channel for this CALC state, map or bypass it.
    always_comb begin
        ch_in_s = 8'd0;
        case (state_q)
            CALC_R:  ch_in_s = r_q;
            CALC_G:  ch_in_s = g_q;
            CALC_B:  ch_in_s = b_q;
            default: ch_in_s = 8'd0;
        endcase
        if (en_q) begin
            ch_out_s = inv_map(ch_in_s);
        end else begin
            ch_out_s = ch_in_s;
        end
    end

    // FSM state plus handshake flags, registered from the next state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            valid_q <= (state_d == OUT);
            ready_q <= (state_d == IDLE);
        end
    end

    // Input capture on accept.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_q  <= 8'd0;
            g_q  <= 8'd0;
            b_q  <= 8'd0;
            en_q <= 1'b0;
        end else if ((state_q == IDLE) && valid_i) begin
            r_q  <= r_i;
            g_q  <= g_i;
            b_q  <= b_i;
            en_q <= en_i;
        end
    end

    // Result registers; each is written only in its own CALC state, so OUT holds them.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_out_q <= 8'd0;
            g_out_q <= 8'd0;
            b_out_q <= 8'd0;
        end else begin
            if (state_q == CALC_R) r_out_q <= ch_out_s;
            if (state_q == CALC_G) g_out_q <= ch_out_s;
            if (state_q == CALC_B) b_out_q <= ch_out_s;
        end
    end

    assign ready_i = ready_q;
    assign valid_o = valid_q;
    assign r_o     = r_out_q;
    assign g_o     = g_out_q;
    assign b_o     = b_out_q;

endmodule
